// File: rtl/comp_run_ctrl.sv
// Program loader and output capture wrapped around the comp core.
// Load path: one-cycle registered oob write per accepted word; capture is same-cycle; reads return one cycle after rd_en.
// load_ready is high only in LOAD; capture drops entries once the buffer is full; reads are honoured only in DONE.
module comp_run_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int OUT_DEPTH = 32,
   parameter int OUT_PTR_W = 5,
   parameter int TIMEOUT   = 100
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [DATA_W-1:0]    load_data,
   input  logic                 load_last,
   output logic                 core_rst,
   output logic                 oob_wen,
   output logic [31:0]          oob_wr_addr,
   output logic [DATA_W-1:0]    oob_wr_data,
   input  logic [DATA_W-1:0]    core_out,
   input  logic                 core_outen,
   input  logic                 core_outflen,
   input  logic                 core_halt,
   input  logic                 rd_en,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_flt,
   output logic                 rd_valid,
   output logic [OUT_PTR_W:0]   out_count,
   output logic [2:0]           state,
   output logic                 done,
   output logic                 timed_out,
   output logic                 overflow
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_DONE   = 3'd4
   } st_t;

   localparam int                 CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]   CYC_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [OUT_PTR_W:0] CNT_FULL = (OUT_PTR_W + 1)'(OUT_DEPTH);
   localparam logic [ADDR_W-1:0]  IDX_LAST = '1;

   st_t                cur_st;
   st_t                nxt_st;
   logic [ADDR_W-1:0]  load_idx;
   logic [CNT_W-1:0]   cyc_cnt;
   logic [OUT_PTR_W:0] rd_ptr;
   logic [DATA_W:0]    buf_mem [OUT_DEPTH];
   logic [DATA_W:0]    rd_entry;

   logic accept;
   logic last_word;
   logic cap;
   logic buf_full;
   logic timeout_hit;
   logic start_ok;
   logic pop;

   assign accept      = (cur_st == ST_LOAD) && load_valid;
   assign last_word   = load_last || (load_idx == IDX_LAST);
   assign cap         = (cur_st == ST_RUN) && (core_outen || core_outflen);
   assign buf_full    = (out_count == CNT_FULL);
   assign timeout_hit = (cyc_cnt == CYC_LAST);
   assign start_ok    = start && ((cur_st == ST_IDLE) || (cur_st == ST_DONE));
   assign pop         = (cur_st == ST_DONE) && rd_en && (rd_ptr < out_count);
   assign rd_entry    = buf_mem[rd_ptr[OUT_PTR_W-1:0]];

   // Status outputs decode straight from the state register.
   assign state      = cur_st;
   assign load_ready = (cur_st == ST_LOAD);
   assign core_rst   = (cur_st != ST_RUN);
   assign done       = (cur_st == ST_DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) cur_st <= ST_IDLE;
      else     cur_st <= nxt_st;
   end

   // Next-state logic; halt is checked before timeout so a coincident halt is a clean stop.
   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         ST_IDLE:   if (start) nxt_st = ST_LOAD;
         ST_LOAD:   if (accept && last_word) nxt_st = ST_SETTLE;
         ST_SETTLE: nxt_st = ST_RUN;
         ST_RUN:    if (core_halt || timeout_hit) nxt_st = ST_DONE;
         ST_DONE:   if (start) nxt_st = ST_LOAD;
         default:   nxt_st = ST_IDLE;
      endcase
   end

   // Load write port, run counter, capture bookkeeping and read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         oob_wen     <= 1'b0;
         oob_wr_addr <= '0;
         oob_wr_data <= '0;
         load_idx    <= '0;
         cyc_cnt     <= '0;
         out_count   <= '0;
         rd_ptr      <= '0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         rd_flt      <= 1'b0;
         timed_out   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         oob_wen <= accept;
         if (accept) begin
            oob_wr_addr <= {{(32 - ADDR_W){1'b0}}, load_idx};
            oob_wr_data <= load_data;
            load_idx    <= load_idx + 1'b1;
         end

         if (cur_st == ST_RUN) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (cap) begin
               if (buf_full) overflow  <= 1'b1;
               else          out_count <= out_count + 1'b1;
            end
            if (!core_halt && timeout_hit) timed_out <= 1'b1;
         end

         rd_valid <= 1'b0;
         if (pop) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_entry[DATA_W-1:0];
            rd_flt   <= rd_entry[DATA_W];
            rd_ptr   <= rd_ptr + 1'b1;
         end

         // A new run wipes all per-run bookkeeping; placed last so it wins over a same-cycle pop.
         if (start_ok) begin
            load_idx  <= '0;
            out_count <= '0;
            rd_ptr    <= '0;
            cyc_cnt   <= '0;
            timed_out <= 1'b0;
            overflow  <= 1'b0;
         end
      end
   end

   // Capture storage; deliberately not reset, only out_count says what is valid.
   always_ff @(posedge clk) begin
      if (!rst && cap && !buf_full)
         buf_mem[out_count[OUT_PTR_W-1:0]] <= {core_outflen, core_out};
   end

endmodule
